bias_act: RTL and testbench

Post-matmul stage of the neural-net datapath. It takes the H×W float result matrix from the matrix multiplier when that block's `done` rises, adds a per-column bias, and optionally applies ReLU. The result is a registered matrix plus a done flag for the next layer. The stage time-multiplexes a single `add_float` core over all H*W elements to save area.

---
 rtl/bias_act.sv | 262 ++++++++++++++++++++++++++
 tb/tb_bias_act.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bias_act.sv
// rtl/bias_act.sv - per-column bias add with optional ReLU over an HxW float matrix.
// One shared two-cycle float adder is stepped over the elements in row-major order.

module add_float #(
  parameter int S = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         sub,
  output logic [S-1:0] y,
  output logic         done,
  output logic         nan,
  output logic         overflow
);
  localparam int EW = (S == 64) ? 11 : (S == 16) ? 5 : 8;
  localparam int FW = S - 1 - EW;
  localparam int M  = FW + 1;
  localparam int X  = M + 3;
  localparam logic [EW-1:0] EMAX = '1;

  logic [S-1:0] a_q, b_q, y_q;
  logic         s1_q, done_q, nan_q, ovf_q;

  logic          sa, sb, sx, a_nan, b_nan, a_inf, b_inf, swap, st, g, rs, up;
  logic          nan_c, ovf_c;
  logic [EW-1:0] ea, eb;
  logic [EW+1:0] ex, ey, d, e;
  logic [M-1:0]  mx, my, mant;
  logic [X-1:0]  yy, m;
  logic [X:0]    sum;
  logic [M:0]    mr;
  logic [S-1:0]  y_c;

  // Operands are captured on start; the result is registered one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
      s1_q   <= 1'b0;
      done_q <= 1'b0;
      nan_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q <= start;
      if (start) begin
        a_q <= a;
        b_q <= {b[S-1] ^ sub, b[S-2:0]};
      end
      if (s1_q) begin
        y_q   <= y_c;
        nan_q <= nan_c;
        ovf_q <= ovf_c;
      end
      done_q <= done_q | s1_q;
    end
  end

  always_comb begin
    sa    = a_q[S-1];
    sb    = b_q[S-1];
    ea    = a_q[S-2 -: EW];
    eb    = b_q[S-2 -: EW];
    a_nan = (ea == EMAX) && (a_q[FW-1:0] != '0);
    b_nan = (eb == EMAX) && (b_q[FW-1:0] != '0);
    a_inf = (ea == EMAX) && (a_q[FW-1:0] == '0);
    b_inf = (eb == EMAX) && (b_q[FW-1:0] == '0);
    swap  = b_q[S-2:0] > a_q[S-2:0];
    sx    = swap ? sb : sa;
    mx    = swap ? {eb != '0, b_q[FW-1:0]} : {ea != '0, a_q[FW-1:0]};
    my    = swap ? {ea != '0, a_q[FW-1:0]} : {eb != '0, b_q[FW-1:0]};
    ex    = (EW+2)'(swap ? eb : ea);
    ey    = (EW+2)'(swap ? ea : eb);
    // Subnormals share the minimum normal exponent.
    if (ex == '0) ex = (EW+2)'(1);
    if (ey == '0) ey = (EW+2)'(1);
    d  = ex - ey;
    yy = {my, 3'b000};
    st = 1'b0;
    if (d >= (EW+2)'(X)) begin
      st = |my;
      yy = '0;
    end else begin
      for (int i = 0; i < X; i++) begin
        if (i < int'(d)) st = st | yy[i];
      end
      yy = yy >> d;
    end
    yy[0] = yy[0] | st;
    sum = (sa ^ sb) ? ({1'b0, mx, 3'b000} - {1'b0, yy}) : ({1'b0, mx, 3'b000} + {1'b0, yy});
    e = ex;
    if (sum[X]) begin
      m    = sum[X:1];
      m[0] = m[0] | sum[0];
      e    = e + 1'b1;
    end else begin
      m = sum[X-1:0];
    end
    for (int i = 0; i < X; i++) begin
      if (!m[X-1] && (m != '0) && (e > (EW+2)'(1))) begin
        m = m << 1;
        e = e - 1'b1;
      end
    end
    mant = m[X-1:3];
    g    = m[2];
    rs   = m[1] | m[0];
    up   = g & (rs | mant[0]);
    mr   = {1'b0, mant} + (M+1)'(up);
    if (mr[M]) begin
      mant = mr[M:1];
      e    = e + 1'b1;
    end else begin
      mant = mr[M-1:0];
    end
    y_c   = '0;
    nan_c = 1'b0;
    ovf_c = 1'b0;
    if (a_nan) begin
      y_c       = a_q;
      y_c[FW-1] = 1'b1;
      nan_c     = 1'b1;
    end else if (b_nan) begin
      y_c       = b_q;
      y_c[FW-1] = 1'b1;
      nan_c     = 1'b1;
    end else if (a_inf && b_inf && (sa != sb)) begin
      y_c   = {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}};
      nan_c = 1'b1;
    end else if (a_inf) begin
      y_c = {sa, EMAX, {FW{1'b0}}};
    end else if (b_inf) begin
      y_c = {sb, EMAX, {FW{1'b0}}};
    end else if (e >= (EW+2)'(EMAX)) begin
      y_c   = {sx, EMAX, {FW{1'b0}}};
      ovf_c = 1'b1;
    end else if (mant == '0) begin
      y_c = {sa & sb, {(S-1){1'b0}}};
    end else begin
      y_c = {sx, (mant[M-1] ? e[EW-1:0] : {EW{1'b0}}), mant[FW-1:0]};
    end
  end

  assign y        = y_q;
  assign done     = done_q;
  assign nan      = nan_q;
  assign overflow = ovf_q;
endmodule

module bias_act #(
  parameter int S    = 32,
  parameter int H    = 2,
  parameter int W    = 2,
  parameter int RELU = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [S*H*W-1:0] in,
  input  logic [S*W-1:0]   bias,
  output logic [S*H*W-1:0] out,
  output logic             done,
  output logic             busy,
  output logic             err
);
  localparam int N  = H * W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    col_q;
  logic [S*N-1:0]   in_q, out_q;
  logic [S*W-1:0]   bias_q;
  logic             err_q;

  logic             add_start, add_rst_n, add_done, add_nan, add_ovf, accept, last;
  logic [S-1:0]     add_a, add_b, add_y, res;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (idx_q == IW'(N - 1));
  assign add_a  = in_q[S*(N-1-int'(idx_q)) +: S];
  assign add_b  = bias_q[S*(W-1-int'(col_q)) +: S];

  always_comb begin
    res = add_y;
    if ((RELU != 0) && add_y[S-1]) res = '0;
  end

  add_float #(.S(S)) u_add (
    .clk      (clk),
    .rst_n    (add_rst_n),
    .start    (add_start),
    .a        (add_a),
    .b        (add_b),
    .sub      (1'b0),
    .y        (add_y),
    .done     (add_done),
    .nan      (add_nan),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      in_q    <= '0;
      bias_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_q   <= in;
        bias_q <= bias;
        out_q  <= '0;
        err_q  <= 1'b0;
        idx_q  <= '0;
        col_q  <= '0;
      end else if (state_q == WRITE) begin
        out_q[S*(N-1-int'(idx_q)) +: S] <= res;
        err_q <= err_q | add_nan | add_ovf;
        if (!last) begin
          idx_q <= idx_q + 1'b1;
          col_q <= (col_q == CW'(W - 1)) ? '0 : col_q + 1'b1;
        end
      end
    end
  end

  // The adder is held in reset outside ISSUE/WAIT so its done clears between elements.
  always_comb begin
    state_d   = state_q;
    add_start = 1'b0;
    add_rst_n = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) state_d = ISSUE;
      ISSUE: begin
        add_rst_n = 1'b1;
        add_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        add_rst_n = 1'b1;
        if (add_done) state_d = WRITE;
      end
      WRITE:   state_d = last ? DONE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  assign out  = out_q;
  assign err  = err_q;
  assign done = (state_q == DONE);
  assign busy = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WRITE);
endmodule

// File: tb/tb_bias_act.sv
// tb/tb_bias_act.sv - directed vector bench for bias_act, RELU=1 and RELU=0 side by side.

module tb_bias_act;
  localparam int LAT = 16;

  typedef struct {
    logic [127:0] in;
    logic [63:0]  bias;
    logic [127:0] exp_r;
    logic [127:0] exp_l;
    logic         exp_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] in_v = '0;
  logic [63:0]  bias_v = '0;
  logic [127:0] out_r, out_l;
  logic         done_r, busy_r, err_r, done_l, busy_l, err_l;

  vec_t vecs [6];
  int   nvec = 0;
  int   nerr = 0;

  bias_act #(.S(32), .H(2), .W(2), .RELU(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_v), .bias(bias_v),
    .out(out_r), .done(done_r), .busy(busy_r), .err(err_r)
  );

  bias_act #(.S(32), .H(2), .W(2), .RELU(0)) u_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_v), .bias(bias_v),
    .out(out_l), .done(done_l), .busy(busy_l), .err(err_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int cyc;
    in_v   = vecs[i].in;
    bias_v = vecs[i].bias;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check($sformatf("v%0d start_clear", i), {busy_r, done_r, err_r, out_r, busy_l, done_l, err_l},
          {1'b1, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 1'b0});
    cyc = 0;
    while (!done_r && cyc < 100) begin
      tick();
      cyc++;
    end
    check($sformatf("v%0d latency", i), 132'(cyc), 132'(LAT));
    check($sformatf("v%0d out_relu", i), 132'(out_r), 132'(vecs[i].exp_r));
    check($sformatf("v%0d out_lin", i), 132'(out_l), 132'(vecs[i].exp_l));
    check($sformatf("v%0d err_busy", i), {err_r, err_l, busy_r, busy_l, done_l},
          {vecs[i].exp_err, vecs[i].exp_err, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    vecs[0] = '{in: 128'h3F800000_40000000_C0400000_3F000000, bias: 64'h3F000000_BF800000,
                exp_r: 128'h3FC00000_3F800000_00000000_00000000,
                exp_l: 128'h3FC00000_3F800000_C0200000_BF000000, exp_err: 1'b0};
    vecs[1] = '{in: 128'h7F7FFFFF_7F7FFFFF_7F7FFFFF_7F7FFFFF, bias: 64'h7F7FFFFF_7F7FFFFF,
                exp_r: 128'h7F800000_7F800000_7F800000_7F800000,
                exp_l: 128'h7F800000_7F800000_7F800000_7F800000, exp_err: 1'b1};
    vecs[2] = '{in: 128'h40400000_00000000_BF800000_41200000, bias: 64'hBF800000_3F800000,
                exp_r: 128'h40000000_3F800000_00000000_41300000,
                exp_l: 128'h40000000_3F800000_C0000000_41300000, exp_err: 1'b0};
    vecs[3] = '{in: 128'hBF800000_BF800000_80000000_3F800000, bias: 64'h80000000_3F800000,
                exp_r: 128'h00000000_00000000_00000000_40000000,
                exp_l: 128'hBF800000_00000000_80000000_40000000, exp_err: 1'b0};
    vecs[4] = '{in: 128'hFFC00000_3F800000_3F800000_3F800000, bias: 64'h3F800000_3F800000,
                exp_r: 128'h00000000_40000000_40000000_40000000,
                exp_l: 128'hFFC00000_40000000_40000000_40000000, exp_err: 1'b1};
    vecs[5] = '{in: 128'h3F800000_3F800001_00000001_00800000, bias: 64'h33800000_00000001,
                exp_r: 128'h3F800000_3F800001_33800000_00800001,
                exp_l: 128'h3F800000_3F800001_33800000_00800001, exp_err: 1'b0};

    tick();
    tick();
    check("reset_state", {busy_r, done_r, err_r, out_r, busy_l, done_l, err_l}, 132'h0);
    rst_n = 1'b1;
    tick();
    check("idle_state", {busy_r, done_r, err_r, out_r, busy_l, done_l, err_l}, 132'h0);

    // Back-to-back: each run starts the cycle after the previous done.
    for (int i = 0; i < 6; i++) run_vec(i);

    // Busy-ignore with changed operands, and start coincident with the final WRITE.
    in_v   = vecs[0].in;
    bias_v = vecs[0].bias;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    in_v   = vecs[1].in;
    bias_v = vecs[1].bias;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("busy_ignore", {busy_r, done_r}, {1'b1, 1'b0});
    for (int k = 0; k < 9; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_done_at_lat", {done_r, busy_r}, {1'b1, 1'b0});
    tick();
    check("hold_done_after", {done_r, done_l, err_r}, {1'b1, 1'b1, 1'b0});
    check("hold_out_relu", 132'(out_r), 132'(vecs[0].exp_r));
    check("hold_out_lin", 132'(out_l), 132'(vecs[0].exp_l));

    // Reset during WAIT of element 2.
    in_v   = vecs[0].in;
    bias_v = vecs[0].bias;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check("partial_out", 132'(out_r), 132'(128'h3FC00000_3F800000_00000000_00000000));
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy_r, done_r, err_r, out_r, busy_l, done_l, err_l}, 132'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
